// File: rtl/dpd_pkg.sv
// Shared DPD definitions: capture FSM states and the sample/address widths
// common to the training-signal player and the feedback capture buffer.
package dpd_pkg;

  localparam int DPD_W  = 16;
  localparam int DPD_AW = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/dpd_sig_capture_if.sv
// Feedback sample stream and buffer read bus of the DPD capture block.
interface dpd_sig_capture_if
  import dpd_pkg::*;
#(
  parameter int W  = DPD_W,
  parameter int AW = DPD_AW
) ();

  logic          fb_valid;
  logic [W-1:0]  fb_i;
  logic [W-1:0]  fb_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_i;
  logic [W-1:0]  rd_q;

  modport master (output fb_valid, fb_i, fb_q, rd_en, rd_addr, input rd_i, rd_q);
  modport slave  (input fb_valid, fb_i, fb_q, rd_en, rd_addr, output rd_i, rd_q);

endinterface

// File: rtl/dpd_cap_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module dpd_cap_ram #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; the array itself keeps stale contents.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)   rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/dpd_sig_capture.sv
// DPD feedback capture buffer: arm on start rise, wait loop delay, store 2^AW I/Q samples.
// Optional DPD_CAP_PEAK_EN adds a peak |I|+|Q| output for feedback-gain normalisation.
module dpd_sig_capture
  import dpd_pkg::*;
#(
  parameter int W  = DPD_W,
  parameter int AW = DPD_AW,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  input  logic [DW-1:0] delay,
  output logic          busy,
  output logic          done,
  dpd_sig_capture_if.slave cap
`ifdef DPD_CAP_PEAK_EN
  ,
  output logic [W:0]    peak
`endif
);

  logic          s0_reg, s1_reg, arm_reg;
  cap_state_t    state_reg, state_next;
  logic [DW-1:0] dly_cnt_reg, dly_cnt_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic          busy_reg, done_reg;
  logic          we;
  logic          arm_accept;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s0_reg      <= 1'b0;
      s1_reg      <= 1'b0;
      arm_reg     <= 1'b0;
      state_reg   <= IDLE;
      dly_cnt_reg <= '0;
      wr_addr_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      s0_reg      <= start;
      s1_reg      <= s0_reg;
      arm_reg     <= s0_reg & ~s1_reg;
      state_reg   <= state_next;
      dly_cnt_reg <= dly_cnt_next;
      wr_addr_reg <= wr_addr_next;
      busy_reg    <= (state_next == DELAY) || (state_next == CAPTURE);
      done_reg    <= (state_next == DONE);
    end
  end

  // Arms arriving while a capture is in flight fall through untouched.
  always_comb begin
    state_next   = state_reg;
    dly_cnt_next = dly_cnt_reg;
    wr_addr_next = wr_addr_reg;
    we           = 1'b0;
    arm_accept   = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (arm_reg) begin
          arm_accept   = 1'b1;
          dly_cnt_next = delay;
          wr_addr_next = '0;
          state_next   = (delay != '0) ? DELAY : CAPTURE;
        end
      end
      DELAY: begin
        dly_cnt_next = dly_cnt_reg - 1'b1;
        if (dly_cnt_reg == DW'(1)) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (cap.fb_valid) begin
          we           = 1'b1;
          wr_addr_next = wr_addr_reg + 1'b1;
          if (&wr_addr_reg) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;

  logic [W-1:0] wr_data_arr [2];
  logic [W-1:0] rd_data_arr [2];

  assign wr_data_arr[0] = cap.fb_i;
  assign wr_data_arr[1] = cap.fb_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ram
      dpd_cap_ram #(.W(W), .AW(AW)) u_ram (
        .clk     (clk),
        .reset_b (reset_b),
        .we      (we),
        .wr_addr (wr_addr_reg),
        .wr_data (wr_data_arr[gi]),
        .rd_en   (cap.rd_en),
        .rd_addr (cap.rd_addr),
        .rd_data (rd_data_arr[gi])
      );
    end
  endgenerate

  assign cap.rd_i = rd_data_arr[0];
  assign cap.rd_q = rd_data_arr[1];

`ifdef DPD_CAP_PEAK_EN
  // Most-negative input saturates so |x| always fits in W-1 magnitude bits.
  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
    logic [W-1:0] r;
    if (!x[W-1])             r = x;
    else if (x[W-2:0] == '0) r = {1'b0, {(W-1){1'b1}}};
    else                     r = -x;
    return r;
  endfunction

  logic [W:0] mag;
  logic [W:0] peak_reg;

  assign mag = {1'b0, abs_sat(cap.fb_i)} + {1'b0, abs_sat(cap.fb_q)};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                 peak_reg <= '0;
    else if (arm_accept)          peak_reg <= '0;
    else if (we && mag > peak_reg) peak_reg <= mag;
  end

  assign peak = peak_reg;
`endif

endmodule

// File: tb/tb_dpd_sig_capture.sv
// Directed self-checking bench for dpd_sig_capture (delay, valid gaps, re-arm, reset, peak).
module tb_dpd_sig_capture;
  import dpd_pkg::*;

  localparam int W  = 16;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dly = '0;
  logic          busy, done;
`ifdef DPD_CAP_PEAK_EN
  logic [W:0]    peak;
`endif

  int checks = 0;
  int failures = 0;

  dpd_sig_capture_if #(.W(W), .AW(AW)) cap ();

  dpd_sig_capture #(.W(W), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (start),
    .delay   (dly),
    .busy    (busy),
    .done    (done),
    .cap     (cap.slave)
`ifdef DPD_CAP_PEAK_EN
    ,
    .peak    (peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic read_word(input logic [AW-1:0] a, output logic [W-1:0] ri, output logic [W-1:0] rq);
    @(negedge clk);
    cap.rd_en   = 1'b1;
    cap.rd_addr = a;
    @(negedge clk);
    cap.rd_en = 1'b0;
    ri = cap.rd_i;
    rq = cap.rd_q;
  endtask

  // Drives one capture; k counts negedges after start rises, sample k is taken at posedge k+1.
  task automatic capture_run(input int mode, input logic [DW-1:0] d, input int glitch_k,
                             input int reset_k, input int rd_k,
                             output int busy_cyc, output int done_cyc,
                             output logic done_at_busy, output logic [W-1:0] rd_val);
    logic [W-1:0] fbi, fbq;
    logic         vld;
    busy_cyc = -1;
    done_cyc = -1;
    done_at_busy = 1'b0;
    rd_val = '0;
    @(negedge clk);
    dly = d;
    start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      vld = 1'b1;
      fbi = W'(k);
      fbq = '0;
      case (mode)
        0: fbi = W'(k - 3);
        1: fbi = W'(k);
        2: begin vld = (k % 2 == 0); fbi = vld ? W'(k) : 16'hDEAD; end
        3: fbi = W'(k - 3 + 16'h4000);
        default: begin fbi = (k == 100) ? 16'h8000 : '0; fbq = (k == 100) ? 16'd100 : '0; end
      endcase
      if (mode != 4) fbq = ~fbi;
      cap.fb_valid = vld;
      cap.fb_i     = fbi;
      cap.fb_q     = fbq;
      if (k == glitch_k)     start = 1'b0;
      if (k == glitch_k + 1) start = 1'b1;
      cap.rd_en   = (k == rd_k);
      cap.rd_addr = '0;
      if (k == reset_k) begin
        reset_b = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (k == rd_k) rd_val = cap.rd_i;
      if (busy && busy_cyc < 0) begin
        busy_cyc = k + 1;
        done_at_busy = done;
      end
      if (done && busy_cyc >= 0 && done_cyc < 0) done_cyc = k + 1;
      if (done_cyc >= 0) break;
    end
    cap.rd_en = 1'b0;
    cap.fb_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (cap.rd_i !== '0) begin failures++; $display("FAIL reset_rd_i: got %0h expected 0", cap.rd_i); end
    checks++; if (cap.rd_q !== '0) begin failures++; $display("FAIL reset_rd_q: got %0h expected 0", cap.rd_q); end
`ifdef DPD_CAP_PEAK_EN
    checks++; if (peak !== '0) begin failures++; $display("FAIL reset_peak: got %0d expected 0", peak); end
`endif
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int bc, dc; logic dab; logic [W-1:0] rv, ri, rq;
    capture_run(0, 8'd0, -10, -1, -1, bc, dc, dab, rv);
    $display("basic capture busy_at=%0d done_at=%0d", bc, dc);
    checks++; if (bc !== 3) begin failures++; $display("FAIL basic_busy_rise: got %0d expected 3", bc); end
    checks++; if (dc - bc !== 1024) begin failures++; $display("FAIL basic_capture_len: got %0d expected 1024", dc - bc); end
    read_word(10'd0, ri, rq);
    checks++; if (ri !== 16'd0) begin failures++; $display("FAIL basic_rd0: got %0d expected 0", ri); end
    read_word(10'd512, ri, rq);
    checks++; if (ri !== 16'd512) begin failures++; $display("FAIL basic_rd512: got %0d expected 512", ri); end
    checks++; if (rq !== 16'hFDFF) begin failures++; $display("FAIL basic_rdq512: got %0h expected fdff", rq); end
    read_word(10'd1023, ri, rq);
    checks++; if (ri !== 16'd1023) begin failures++; $display("FAIL basic_rd1023: got %0d expected 1023", ri); end
    @(negedge clk);
    cap.rd_addr = 10'd5;
    @(negedge clk);
    checks++; if (cap.rd_i !== 16'd1023) begin failures++; $display("FAIL basic_rd_hold: got %0d expected 1023", cap.rd_i); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_held: got %0b expected 1", done); end
  endtask

  task automatic test_rearm_mid_capture();
    int bc, dc; logic dab; logic [W-1:0] rv, ri, rq;
    capture_run(0, 8'd0, 302, -1, -1, bc, dc, dab, rv);
    $display("rearm capture busy_at=%0d done_at=%0d", bc, dc);
    checks++; if (dab !== 1'b0) begin failures++; $display("FAIL rearm_done_drop: got %0b expected 0", dab); end
    checks++; if (dc !== 1027) begin failures++; $display("FAIL rearm_done_time: got %0d expected 1027", dc); end
    read_word(10'd300, ri, rq);
    checks++; if (ri !== 16'd300) begin failures++; $display("FAIL rearm_rd300: got %0d expected 300", ri); end
    read_word(10'd1023, ri, rq);
    checks++; if (ri !== 16'd1023) begin failures++; $display("FAIL rearm_rd1023: got %0d expected 1023", ri); end
  endtask

  task automatic test_delay();
    int bc, dc; logic dab; logic [W-1:0] rv, ri, rq;
    capture_run(1, 8'd5, -10, -1, 8, bc, dc, dab, rv);
    $display("delay capture busy_at=%0d done_at=%0d", bc, dc);
    checks++; if (dc !== 1032) begin failures++; $display("FAIL delay_done_time: got %0d expected 1032", dc); end
    checks++; if (rv !== 16'd0) begin failures++; $display("FAIL delay_read_first: got %0d expected 0", rv); end
    read_word(10'd0, ri, rq);
    checks++; if (ri !== 16'd8) begin failures++; $display("FAIL delay_rd0: got %0d expected 8", ri); end
    read_word(10'd1023, ri, rq);
    checks++; if (ri !== 16'd1031) begin failures++; $display("FAIL delay_rd1023: got %0d expected 1031", ri); end
  endtask

  task automatic test_valid_gaps();
    int bc, dc; logic dab; logic [W-1:0] rv, ri, rq;
    capture_run(2, 8'd0, -10, -1, -1, bc, dc, dab, rv);
    $display("gap capture busy_at=%0d done_at=%0d", bc, dc);
    checks++; if (dc - bc !== 2048) begin failures++; $display("FAIL gaps_capture_len: got %0d expected 2048", dc - bc); end
    read_word(10'd0, ri, rq);
    checks++; if (ri !== 16'd4) begin failures++; $display("FAIL gaps_rd0: got %0d expected 4", ri); end
    read_word(10'd1, ri, rq);
    checks++; if (ri !== 16'd6) begin failures++; $display("FAIL gaps_rd1: got %0d expected 6", ri); end
    checks++; if (rq !== 16'hFFF9) begin failures++; $display("FAIL gaps_rdq1: got %0h expected fff9", rq); end
    read_word(10'd1023, ri, rq);
    checks++; if (ri !== 16'd2050) begin failures++; $display("FAIL gaps_rd1023: got %0d expected 2050", ri); end
  endtask

  task automatic test_reset_mid_capture();
    int bc, dc; logic dab; logic [W-1:0] rv, ri, rq;
    capture_run(0, 8'd0, -10, 703, -1, bc, dc, dab, rv);
    #1;
    $display("reset asserted mid capture busy=%0b done=%0b", busy, done);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %0b expected 0", done); end
    start = 1'b0;
    cap.fb_valid = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    capture_run(3, 8'd0, -10, -1, -1, bc, dc, dab, rv);
    $display("post-reset capture busy_at=%0d done_at=%0d", bc, dc);
    checks++; if (bc !== 3) begin failures++; $display("FAIL postreset_busy_rise: got %0d expected 3", bc); end
    checks++; if (dc - bc !== 1024) begin failures++; $display("FAIL postreset_len: got %0d expected 1024", dc - bc); end
    read_word(10'd0, ri, rq);
    checks++; if (ri !== 16'h4000) begin failures++; $display("FAIL postreset_rd0: got %0h expected 4000", ri); end
    checks++; if (rq !== 16'hBFFF) begin failures++; $display("FAIL postreset_rdq0: got %0h expected bfff", rq); end
    read_word(10'd1023, ri, rq);
    checks++; if (ri !== 16'h43FF) begin failures++; $display("FAIL postreset_rd1023: got %0h expected 43ff", ri); end
  endtask

`ifdef DPD_CAP_PEAK_EN
  task automatic test_peak();
    int bc, dc; logic dab; logic [W-1:0] rv;
    capture_run(4, 8'd0, -10, -1, -1, bc, dc, dab, rv);
    $display("peak capture done_at=%0d peak=%0d", dc, peak);
    checks++; if (peak !== 17'd32867) begin failures++; $display("FAIL peak_value: got %0d expected 32867", peak); end
  endtask
`endif

  initial begin
    cap.fb_valid = 1'b0;
    cap.fb_i = '0;
    cap.fb_q = '0;
    cap.rd_en = 1'b0;
    cap.rd_addr = '0;
    test_reset();
    test_basic();
    test_rearm_mid_capture();
    test_delay();
    test_valid_gaps();
    test_reset_mid_capture();
`ifdef DPD_CAP_PEAK_EN
    test_peak();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
